// File: rtl/mult_pkg.sv
// Shared widths and step constants for the nibble-serial multiply datapath.
package mult_pkg;
  localparam int NIBBLE_W  = 4;
  localparam int NUM_STEPS = 16;
  localparam int SHIFT_MAX = 6;
  localparam int OP_W      = 16;
  localparam int PROD_W    = 32;
  localparam int CNT_W     = $clog2(NUM_STEPS);
endpackage

// File: rtl/mult4x4.sv
// Unsigned 4x4 -> 8-bit nibble multiplier; purely combinational, no flow control.
module mult4x4
  import mult_pkg::*;
(
  input  logic [NIBBLE_W-1:0]   a,
  input  logic [NIBBLE_W-1:0]   b,
  output logic [2*NIBBLE_W-1:0] p
);

  assign p = {{NIBBLE_W{1'b0}}, a} * {{NIBBLE_W{1'b0}}, b};

endmodule

// File: rtl/mult_datapath.sv
// Nibble-serial 16x16 multiply datapath: one shifted 4x4 partial product per enabled edge, no stall path.
// Define MULT_OUT_HOLD_EN to drive product from a hold register captured on done.
module mult_datapath
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset_a,
  input  logic [OP_W-1:0]   dataa,
  input  logic [OP_W-1:0]   datab,
  input  logic [3:0]        input_sel,
  input  logic [2:0]        shift_sel,
  input  logic              clk_ena,
  input  logic              sclr_n,
  input  logic              done,
  output logic [CNT_W-1:0]  count,
  output logic [PROD_W-1:0] product
);

  logic [OP_W-1:0]       a_q, a_d;
  logic [OP_W-1:0]       b_q, b_d;
  logic [PROD_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [NIBBLE_W-1:0]   a_nib, b_nib;
  logic [2*NIBBLE_W-1:0] pp;
  logic [PROD_W-1:0]     pp_shifted;

  // Nibble selection always reads the latched operands, never the live inputs.
  assign a_nib = a_q[input_sel[3:2]*NIBBLE_W +: NIBBLE_W];
  assign b_nib = b_q[input_sel[1:0]*NIBBLE_W +: NIBBLE_W];

  mult4x4 u_mult4x4 (
    .a (a_nib),
    .b (b_nib),
    .p (pp)
  );

  // Shift codes beyond SHIFT_MAX contribute nothing; bits above the product width drop off.
  always_comb begin
    pp_shifted = '0;
    if (int'(shift_sel) <= SHIFT_MAX)
      pp_shifted = PROD_W'(pp) << (NIBBLE_W*int'(shift_sel));
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    count_d = count_q;
    if (clk_ena) begin
      if (!sclr_n) begin
        a_d     = dataa;
        b_d     = datab;
        acc_d   = '0;
        count_d = '0;
      end else begin
        acc_d   = acc_q + pp_shifted;
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef MULT_OUT_HOLD_EN
  logic [PROD_W-1:0] hold_q, hold_d;

  // The hold register obeys the same enable as the rest of the datapath.
  always_comb begin
    hold_d = hold_q;
    if (clk_ena && done)
      hold_d = acc_q;
  end

  always_ff @(posedge clk or posedge reset_a) begin
    if (reset_a)
      hold_q <= '0;
    else
      hold_q <= hold_d;
  end

  assign product = hold_q;
`else
  logic done_unused;
  assign done_unused = done;
  assign product     = acc_q;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath: directed multiplies plus random steps against an arithmetic model.
module tb_mult_datapath;

  logic        clk = 1'b0;
  logic        reset_a;
  logic [15:0] dataa, datab;
  logic [3:0]  input_sel;
  logic [2:0]  shift_sel;
  logic        clk_ena, sclr_n, done;
  logic [3:0]  count;
  logic [31:0] product;

  always #5 clk = ~clk;

  mult_datapath dut (
    .clk       (clk),
    .reset_a   (reset_a),
    .dataa     (dataa),
    .datab     (datab),
    .input_sel (input_sel),
    .shift_sel (shift_sel),
    .clk_ena   (clk_ena),
    .sclr_n    (sclr_n),
    .done      (done),
    .count     (count),
    .product   (product)
  );

  // Reference state: what the operands, running sum, step count and held result should be.
  logic [15:0] m_a, m_b;
  logic [31:0] m_acc, m_hold;
  logic [3:0]  m_cnt;
  int          n_assert = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] visible_product();
`ifdef MULT_OUT_HOLD_EN
    return m_hold;
`else
    return m_acc;
`endif
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one clock's inputs, advance the model by the arithmetic rule, then compare outputs.
  task automatic cycle(input logic ena, input logic ld_n, input logic [3:0] sel,
                       input logic [2:0] sh, input logic dn, input string tag);
    logic [3:0]  an, bn;
    logic [63:0] contrib;
    clk_ena   = ena;
    sclr_n    = ld_n;
    input_sel = sel;
    shift_sel = sh;
    done      = dn;
    if (ena) begin
      if (dn) m_hold = m_acc;
      if (!ld_n) begin
        m_a   = dataa;
        m_b   = datab;
        m_acc = 32'd0;
        m_cnt = 4'd0;
      end else begin
        an      = 4'(m_a >> (4 * int'(sel[3:2])));
        bn      = 4'(m_b >> (4 * int'(sel[1:0])));
        contrib = (sh == 3'd7) ? 64'd0 : ((64'(an) * 64'(bn)) << (4 * int'(sh)));
        m_acc   = m_acc + contrib[31:0];
        m_cnt   = m_cnt + 4'd1;
      end
    end
    @(posedge clk);
    #1;
    check32({tag, " product"}, product, visible_product());
    check32({tag, " count"}, {28'd0, count}, {28'd0, m_cnt});
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] b, input logic dn, input string tag);
    dataa = a;
    datab = b;
    cycle(1'b1, 1'b0, 4'd0, 3'd0, dn, tag);
  endtask

  // Controller order: step k uses A nibble k/4, B nibble k%4, shifted by their index sum.
  task automatic steps(input int k0, input int k1, input string tag);
    for (int k = k0; k < k1; k++)
      cycle(1'b1, 1'b1, {2'(k / 4), 2'(k % 4)}, 3'((k / 4) + (k % 4)), 1'b0, tag);
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [31:0] full;
    reset_a   = 1'b1;
    dataa     = 16'd0;
    datab     = 16'd0;
    input_sel = 4'd0;
    shift_sel = 3'd0;
    clk_ena   = 1'b0;
    sclr_n    = 1'b1;
    done      = 1'b0;
    m_a = 16'd0; m_b = 16'd0; m_acc = 32'd0; m_hold = 32'd0; m_cnt = 4'd0;

    #3;
    check32("reset product", product, 32'd0);
    check32("reset count", {28'd0, count}, 32'd0);
    #4 reset_a = 1'b0;
    @(posedge clk);
    #1;

    load(16'hFFFF, 16'hFFFF, 1'b0, "load_ffff");
    steps(0, 16, "seq_ffff");
`ifndef MULT_OUT_HOLD_EN
    check32("ffff result", product, 32'hFFFE0001);
`endif
    check32("ffff count wrap", {28'd0, count}, 32'd0);

    load(16'h1234, 16'h5678, 1'b0, "load_1234");
    steps(0, 16, "seq_1234");
`ifndef MULT_OUT_HOLD_EN
    check32("1234x5678 result", product, 32'h06260060);
`endif

    ra = 16'($urandom);
    rb = 16'($urandom);
    load(ra, rb, 1'b0, "load_latch");
    steps(0, 8, "latch_a");
    dataa = ~ra;
    datab = 16'($urandom);
    steps(8, 16, "latch_b");
    full = 32'(ra) * 32'(rb);
`ifndef MULT_OUT_HOLD_EN
    check32("latched operands result", product, full);
`endif

    ra = 16'($urandom);
    rb = 16'($urandom);
    load(ra, rb, 1'b0, "load_ena");
    steps(0, 5, "ena_pre");
    for (int n = 0; n < 5; n++)
      cycle(1'b0, 1'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), "ena_low");
    steps(5, 16, "ena_post");
    full = 32'(ra) * 32'(rb);
`ifndef MULT_OUT_HOLD_EN
    check32("ena gap result", product, full);
`endif

    for (int r = 0; r < 3; r++) begin
      load(16'($urandom), 16'($urandom), 1'b0, "load_rand");
      for (int n = 0; n < 20; n++)
        cycle(1'b1, 1'b1, 4'($urandom), 3'($urandom), 1'b0, "rand_step");
    end

    load(16'hABCD, 16'h1357, 1'b0, "load_abort");
    steps(0, 7, "abort_pre");
    #1 reset_a = 1'b1;
    #2;
    m_a = 16'd0; m_b = 16'd0; m_acc = 32'd0; m_hold = 32'd0; m_cnt = 4'd0;
    check32("async reset product", product, 32'd0);
    check32("async reset count", {28'd0, count}, 32'd0);
    #1 reset_a = 1'b0;
    cycle(1'b1, 1'b1, 4'hF, 3'd6, 1'b0, "post_reset_noload");
    load(16'd3, 16'd5, 1'b0, "load_3x5");
    steps(0, 16, "seq_3x5");
`ifndef MULT_OUT_HOLD_EN
    check32("3x5 result", product, 32'h0000000F);
    cycle(1'b1, 1'b1, 4'h0, 3'd0, 1'b1, "done_ignored");
`else
    load(16'd2, 16'd3, 1'b0, "load_2x3");
    steps(0, 16, "seq_2x3");
    load(16'd4, 16'd4, 1'b1, "load_4x4_done");
    check32("hold after done", product, 32'd6);
    steps(0, 16, "seq_4x4");
    check32("hold through run", product, 32'd6);
    cycle(1'b1, 1'b1, 4'h0, 3'd7, 1'b1, "done_4x4");
    check32("hold new result", product, 32'h00000010);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
